// File: rtl/conv2_relu_maxpool_pkg.sv
// Shared definitions for the conv pooling stages: map geometry, pooling phase
// encoding, and the bias/saturate/ReLU and signed max helpers.
package conv2_relu_maxpool_pkg;

    localparam int CONV2_OUT_W = 14;
    localparam int CONV2_MAP_W = 8;
    localparam int CONV2_MAP_H = 8;

    // Position of the current pixel inside its 2x2 window: {row[0], col[0]}
    typedef enum logic [1:0] {
        PH_EVEN_EVEN = 2'b00,
        PH_EVEN_ODD  = 2'b01,
        PH_ODD_EVEN  = 2'b10,
        PH_ODD_ODD   = 2'b11
    } pool_phase_t;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Add bias at full precision, clamp to a w-bit signed range, then ReLU.
    function automatic int relu_sat(input int x, input int bias, input int w = CONV2_OUT_W);
        int s;
        int hi;
        int lo;
        s  = x + bias;
        hi = (1 << (w - 1)) - 1;
        lo = -(1 << (w - 1));
        if (s > hi)
            s = hi;
        else if (s < lo)
            s = lo;
        return (s < 0) ? 0 : s;
    endfunction

endpackage

// File: rtl/conv2_relu_maxpool.sv
// Per-channel conv2 post-processing: bias with saturation, ReLU and 2x2/stride-2
// max pooling over a raster-order pixel stream, one pooled value per window.
module conv2_relu_maxpool
    import conv2_relu_maxpool_pkg::*;
#(
    parameter int                        DATA_W = CONV2_OUT_W,
    parameter int                        IMG_W  = CONV2_MAP_W,
    parameter int                        IMG_H  = CONV2_MAP_H,
    parameter logic signed [DATA_W-1:0]  BIAS   = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_in,
    input  logic [DATA_W-1:0] data_in,
    output logic              valid_out,
    output logic [DATA_W-1:0] data_out,
    output logic              frame_done
);

    localparam int COL_W = (IMG_W > 2) ? $clog2(IMG_W) : 1;
    localparam int ROW_W = (IMG_H > 2) ? $clog2(IMG_H) : 1;
    localparam int LB_N  = IMG_W / 2;
    localparam int IDX_W = (LB_N > 1) ? $clog2(LB_N) : 1;

    logic [COL_W-1:0]  col;
    logic [ROW_W-1:0]  row;
    logic [DATA_W-1:0] h_reg;
    logic [DATA_W-1:0] line_buf [LB_N];

    pool_phase_t       phase;
    logic [IDX_W-1:0]  lb_idx;
    logic [DATA_W-1:0] r_val;
    logic [DATA_W-1:0] hmax;
    logic [DATA_W-1:0] pooled;
    logic              col_last;
    logic              row_last;

    always_comb begin
        phase    = pool_phase_t'({row[0], col[0]});
        lb_idx   = IDX_W'(col >> 1);
        col_last = (col == COL_W'(IMG_W - 1));
        row_last = (row == ROW_W'(IMG_H - 1));
        r_val    = DATA_W'(relu_sat(int'($signed(data_in)), int'(BIAS), DATA_W));
        hmax     = DATA_W'(max2(int'($signed(h_reg)), int'($signed(r_val))));
        pooled   = DATA_W'(max2(int'($signed(line_buf[lb_idx])), int'($signed(hmax))));
    end

    // Line buffer has no reset; it is always rewritten on an even row before use.
    always_ff @(posedge clk) begin
        if (rst) begin
            col        <= '0;
            row        <= '0;
            h_reg      <= '0;
            valid_out  <= 1'b0;
            data_out   <= '0;
            frame_done <= 1'b0;
        end else begin
            valid_out  <= 1'b0;
            frame_done <= 1'b0;
            if (valid_in) begin
                if (col_last) begin
                    col <= '0;
                    if (row_last)
                        row <= '0;
                    else
                        row <= row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end

                unique case (phase)
                    PH_EVEN_EVEN,
                    PH_ODD_EVEN:  h_reg <= r_val;
                    PH_EVEN_ODD:  line_buf[lb_idx] <= hmax;
                    PH_ODD_ODD: begin
                        valid_out  <= 1'b1;
                        data_out   <= pooled;
                        frame_done <= row_last && col_last;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_conv2_relu_maxpool.sv
// Self-checking bench for conv2_relu_maxpool: scoreboard of expected pooled
// values with latency/frame_done checks, plus a table of single-window vectors.
module tb_conv2_relu_maxpool;

    logic        clk = 1'b0;
    logic        rst;
    logic        v0, v1;
    logic [13:0] din;
    logic        vo0, fd0, vo1, fd1;
    logic [13:0] do0, do1;

    always #5 clk = ~clk;

    conv2_relu_maxpool #(.DATA_W(14), .IMG_W(8), .IMG_H(8), .BIAS(14'sd0)) dut0 (
        .clk(clk), .rst(rst), .valid_in(v0), .data_in(din),
        .valid_out(vo0), .data_out(do0), .frame_done(fd0)
    );

    conv2_relu_maxpool #(.DATA_W(14), .IMG_W(8), .IMG_H(8), .BIAS(14'sd100)) dut1 (
        .clk(clk), .rst(rst), .valid_in(v1), .data_in(din),
        .valid_out(vo1), .data_out(do1), .frame_done(fd1)
    );

    typedef struct {
        int val;
        bit fd;
        int due;
    } exp_t;

    typedef struct {
        int tl, tr, bl, br;
        int want;
    } win_vec_t;

    exp_t q0[$];
    exp_t q1[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   frame [8][8];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int ref_px(input int x, input int b);
        int s;
        s = x + b;
        if (s > 8191) s = 8191;
        if (s < -8192) s = -8192;
        if (s < 0) s = 0;
        return s;
    endfunction

    function automatic int ref_win(input int wr, input int wc, input int b);
        int m;
        int v;
        m = 0;
        for (int dr = 0; dr < 2; dr++)
            for (int dc = 0; dc < 2; dc++) begin
                v = ref_px(frame[2*wr+dr][2*wc+dc], b);
                if (v > m) m = v;
            end
        return m;
    endfunction

    task automatic chk(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    task automatic mon(input int sel, input logic vo, input logic [13:0] d, input logic fd);
        exp_t h;
        bit   have;
        have = (sel == 0) ? (q0.size() > 0) : (q1.size() > 0);
        if (have) h = (sel == 0) ? q0[0] : q1[0];
        if (vo) begin
            if (!have) begin
                checks++;
                errors++;
                $display("FAIL dut%0d spurious valid_out: got data %0d want no output", sel, d);
            end else begin
                if (sel == 0) void'(q0.pop_front()); else void'(q1.pop_front());
                chk($sformatf("dut%0d data_out", sel), int'(d), h.val);
                chk($sformatf("dut%0d frame_done", sel), int'(fd), int'(h.fd));
                chk($sformatf("dut%0d latency edge", sel), cyc, h.due);
            end
        end else begin
            if (fd) begin
                checks++;
                errors++;
                $display("FAIL dut%0d frame_done without valid_out: got 1 want 0", sel);
            end
            if (have && h.due <= cyc) begin
                checks++;
                errors++;
                $display("FAIL dut%0d missing output: got none want %0d", sel, h.val);
                if (sel == 0) void'(q0.pop_front()); else void'(q1.pop_front());
            end
        end
    endtask

    always @(negedge clk) begin
        if (!rst || vo0 || vo1) begin
            mon(0, vo0, do0, fd0);
            mon(1, vo1, do1, fd1);
        end
    end

    task automatic send_frame(input int sel, input int gap, input int npix, input int fixed_exp);
        int   b;
        exp_t e;
        b = (sel != 0) ? 100 : 0;
        for (int i = 0; i < npix; i++) begin
            int r;
            int c;
            r = i / 8;
            c = i % 8;
            @(negedge clk);
            din = 14'(frame[r][c]);
            if (sel != 0) v1 = 1'b1; else v0 = 1'b1;
            if ((r % 2 == 1) && (c % 2 == 1)) begin
                e.val = (fixed_exp >= 0) ? fixed_exp : ref_win(r / 2, c / 2, b);
                e.fd  = (r == 7) && (c == 7);
                e.due = cyc + 1;
                if (sel != 0) q1.push_back(e); else q0.push_back(e);
            end
            for (int g = 0; g < gap; g++) begin
                @(negedge clk);
                v0 = 1'b0;
                v1 = 1'b0;
            end
        end
        @(negedge clk);
        v0 = 1'b0;
        v1 = 1'b0;
    endtask

    task automatic drain(input string name);
        repeat (4) @(negedge clk);
        chk({name, " pending q0"}, q0.size(), 0);
        chk({name, " pending q1"}, q1.size(), 0);
    endtask

    task automatic fill_ramp();
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                frame[r][c] = 8 * r + c;
    endtask

    task automatic fill_all(input int v);
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                frame[r][c] = v;
    endtask

    initial begin
        #1_000_000;
        errors++;
        $display("FAIL watchdog: got timeout want completion");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        win_vec_t vecs [6];
        vecs[0] = '{tl: 8191,  tr: 0,  bl: 0,     br: 0,  want: 8191};
        vecs[1] = '{tl: -8192, tr: -1, bl: -8192, br: -1, want: 0};
        vecs[2] = '{tl: 3,     tr: 9,  bl: 4,     br: 2,  want: 9};
        vecs[3] = '{tl: 7,     tr: 7,  bl: 7,     br: 7,  want: 7};
        vecs[4] = '{tl: 0,     tr: 0,  bl: 0,     br: 1,  want: 1};
        vecs[5] = '{tl: -5,    tr: 12, bl: -7,    br: 11, want: 12};

        rst = 1'b1;
        v0  = 1'b0;
        v1  = 1'b0;
        din = '0;
        repeat (3) @(negedge clk);
        chk("reset valid_out", int'(vo0), 0);
        chk("reset data_out", int'(do0), 0);
        chk("reset frame_done", int'(fd0), 0);
        chk("reset valid_out dut1", int'(vo1), 0);
        rst = 1'b0;

        // Ramp frame, full rate
        fill_ramp();
        send_frame(0, 0, 64, -1);
        drain("ramp");

        // All negative
        fill_all(-100);
        send_frame(0, 0, 64, -1);
        drain("negative");

        // Saturation with BIAS=100
        fill_all(-5000);
        frame[0][0] = 8150;
        frame[0][1] = 5;
        frame[1][0] = 5;
        frame[1][1] = 5;
        send_frame(1, 0, 64, -1);
        drain("saturation");

        // Gapped ramp
        fill_ramp();
        send_frame(0, 1, 64, -1);
        drain("gapped");

        // Mid-frame reset after 20 pixels
        send_frame(0, 0, 20, -1);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("midreset valid_out", int'(vo0), 0);
        chk("midreset data_out", int'(do0), 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("post-reset valid_out", int'(vo0), 0);
        send_frame(0, 0, 64, -1);
        drain("midreset");

        // Reset coincident with a window's last pixel: output and pixel dropped
        send_frame(0, 0, 11, -1);
        din = 14'(frame[1][3]);
        v0  = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        v0 = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        chk("rst+pixel valid_out", int'(vo0), 0);
        send_frame(0, 0, 64, -1);
        drain("rst with pixel");

        // Max at each window position in turn
        fill_all(1);
        for (int k = 0; k < 16; k++) begin
            int p;
            p = k % 4;
            frame[2 * (k / 4) + p / 2][2 * (k % 4) + p % 2] = 1000;
        end
        send_frame(0, 0, 64, 1000);
        drain("maxpos");

        // Table of single-window patterns replicated over the frame
        for (int n = 0; n < 6; n++) begin
            for (int wr = 0; wr < 4; wr++)
                for (int wc = 0; wc < 4; wc++) begin
                    frame[2*wr][2*wc]     = vecs[n].tl;
                    frame[2*wr][2*wc+1]   = vecs[n].tr;
                    frame[2*wr+1][2*wc]   = vecs[n].bl;
                    frame[2*wr+1][2*wc+1] = vecs[n].br;
                end
            send_frame(0, 0, 64, vecs[n].want);
            drain($sformatf("table %0d", n));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
